// File: rtl/seven_seg_capture.sv
// Captures a multiplexed, active-low seven-segment display bus and publishes one
// decoded frame (hex value, blank and decimal point per digit) once every position has been seen.
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned NUM_DIGITS    = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     an_in,
  output logic [4*NUM_DIGITS-1:0]   digits_out,
  output logic [NUM_DIGITS-1:0]     blank_out,
  output logic [NUM_DIGITS-1:0]     dp_out,
  output logic                      frame_valid,
  output logic                      decode_err,
  output logic                      an_err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 2);

  logic [7:0]              samp_seg, prev_seg, acc_seg;
  logic [NUM_DIGITS-1:0]   samp_an, prev_an, acc_an;
  logic [7:0]              cnt;
  logic                    acc;
  logic                    same;

  logic [NUM_DIGITS-1:0]   seen, seen_nxt;
  logic [4*NUM_DIGITS-1:0] sh_val, sh_val_nxt;
  logic [NUM_DIGITS-1:0]   sh_blank, sh_blank_nxt;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_nxt;

  logic [NUM_DIGITS-1:0]   act;
  logic                    none_act, multi_act;
  logic                    dec_ok, dec_blank;
  logic [3:0]              dec_val;
  logic                    write;

  assign same = (samp_seg == prev_seg) && (samp_an == prev_an);

  // Sample stage and stability counter; acc fires once, as the counter reaches its ceiling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_seg <= '1;
      samp_an  <= '1;
      prev_seg <= '1;
      prev_an  <= '1;
      cnt      <= '0;
      acc      <= 1'b0;
      acc_seg  <= '1;
      acc_an   <= '1;
    end else begin
      samp_seg <= seg_in;
      samp_an  <= an_in;
      prev_seg <= samp_seg;
      prev_an  <= samp_an;
      if (!same)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 8'd1;
      acc <= same && (cnt == CNT_PRE);
      if (same && (cnt == CNT_PRE)) begin
        acc_seg <= samp_seg;
        acc_an  <= samp_an;
      end
    end
  end

  always_comb begin
    act       = ~acc_an;
    none_act  = (act == '0);
    multi_act = ((act & (act - 1'b1)) != '0);
  end

  always_comb begin
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    dec_val   = 4'h0;
    case (acc_seg[6:0])
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end

  assign write = acc && !none_act && !multi_act && dec_ok;

  always_comb begin
    seen_nxt     = seen;
    sh_val_nxt   = sh_val;
    sh_blank_nxt = sh_blank;
    sh_dp_nxt    = sh_dp;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (write && act[i]) begin
        sh_val_nxt[4*i +: 4] = dec_val;
        sh_blank_nxt[i]      = dec_blank;
        sh_dp_nxt[i]         = ~acc_seg[7];
        seen_nxt[i]          = 1'b1;
      end
    end
  end

  // The completing digit is merged into the published frame on the same edge it is stored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen        <= '0;
      sh_val      <= '0;
      sh_blank    <= '0;
      sh_dp       <= '0;
      digits_out  <= '0;
      blank_out   <= '1;
      dp_out      <= '0;
      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      decode_err  <= acc && !none_act && !multi_act && !dec_ok;
      an_err      <= acc && multi_act;
      sh_val      <= sh_val_nxt;
      sh_blank    <= sh_blank_nxt;
      sh_dp       <= sh_dp_nxt;
      if (write) begin
        if (&seen_nxt) begin
          digits_out  <= sh_val_nxt;
          blank_out   <= sh_blank_nxt;
          dp_out      <= sh_dp_nxt;
          frame_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: a run-length/event model predicts every output each
// cycle, and directed scenarios pin the model with hand-computed results.
module tb_seven_seg_capture;
  localparam int ST = 16;
  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    seg_in = 8'hFF;
  logic [ND-1:0] an_in = '1;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0] blank_out, dp_out;
  logic          frame_valid, decode_err, an_err;

  seven_seg_capture #(.STABLE_CYCLES(ST), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .digits_out(digits_out), .blank_out(blank_out), .dp_out(dp_out),
    .frame_valid(frame_valid), .decode_err(decode_err), .an_err(an_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fv_cnt = 0, de_cnt = 0, ae_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: an accepted pattern is one seen for ST consecutive clocks; its effect is
  // visible two clocks after the ST-th capture (one for the accept, one for the result).
  typedef struct { logic [13:0] pat; int due; } ev_t;
  ev_t q[$];
  logic [13:0] last;
  int run = 0;
  int ecount = 0;
  int sh_val[ND];
  bit sh_bl[ND], sh_dp[ND], seen[ND];
  logic [4*ND-1:0] m_dig;
  logic [ND-1:0] m_bl, m_dp;
  logic m_fv, m_de, m_ae;
  bit chk_en = 0;

  function automatic int seg_value(input logic [7:0] s);
    logic [7:0] b;
    b = s | 8'h80;
    case (b)
      8'hC0: return 0;  8'hF9: return 1;  8'hA4: return 2;  8'hB0: return 3;
      8'h99: return 4;  8'h92: return 5;  8'h82: return 6;  8'hF8: return 7;
      8'h80: return 8;  8'h90: return 9;  8'h88: return 10; 8'h83: return 11;
      8'hC6: return 12; 8'hA1: return 13; 8'h86: return 14; 8'h8E: return 15;
      8'hFF: return 16;
      default: return -1;
    endcase
  endfunction

  task automatic apply(input logic [13:0] pat);
    logic [7:0] s;
    logic [ND-1:0] a;
    int zeros, idx, v;
    bit all;
    s = pat[13:6];
    a = pat[5:0];
    zeros = 0;
    idx = 0;
    for (int i = 0; i < ND; i++) if (!a[i]) begin zeros++; idx = i; end
    if (zeros > 1) m_ae = 1;
    else if (zeros == 1) begin
      v = seg_value(s);
      if (v < 0) m_de = 1;
      else begin
        sh_val[idx] = (v == 16) ? 0 : v;
        sh_bl[idx] = (v == 16);
        sh_dp[idx] = !s[7];
        seen[idx] = 1;
        all = 1;
        for (int i = 0; i < ND; i++) if (!seen[i]) all = 0;
        if (all) begin
          for (int i = 0; i < ND; i++) begin
            m_dig[4*i +: 4] = 4'(sh_val[i]);
            m_bl[i] = sh_bl[i];
            m_dp[i] = sh_dp[i];
            seen[i] = 0;
          end
          m_fv = 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    ev_t e;
    logic [13:0] pat;
    ecount++;
    if (!rst_n) begin
      q.delete();
      last = '1;
      run = 1;
      for (int i = 0; i < ND; i++) begin sh_val[i] = 0; sh_bl[i] = 0; sh_dp[i] = 0; seen[i] = 0; end
      m_dig = '0; m_bl = '1; m_dp = '0;
      m_fv = 0; m_de = 0; m_ae = 0;
      chk_en = 1;
    end else begin
      m_fv = 0; m_de = 0; m_ae = 0;
      while (q.size() > 0 && q[0].due == ecount) begin
        e = q.pop_front();
        apply(e.pat);
      end
      pat = {seg_in, an_in};
      if (pat == last) run++;
      else begin run = 1; last = pat; end
      if (run == ST) q.push_back('{pat, ecount + 2});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("digits_out", 32'(digits_out), 32'(m_dig));
      check("blank_out", 32'(blank_out), 32'(m_bl));
      check("dp_out", 32'(dp_out), 32'(m_dp));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("decode_err", 32'(decode_err), 32'(m_de));
      check("an_err", 32'(an_err), 32'(m_ae));
      if (frame_valid === 1'b1) fv_cnt++;
      if (decode_err === 1'b1) de_cnt++;
      if (an_err === 1'b1) ae_cnt++;
    end
  end

  logic [7:0]    SEGS[ND] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
  logic [ND-1:0] ANS[ND]  = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

  task automatic hold(input logic [7:0] s, input logic [ND-1:0] a, input int n);
    seg_in = s;
    an_in = a;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) hold(SEGS[i], ANS[i], 20);
    hold(8'hFF, '1, 4);
  endtask

  int f0, d0, a0;

  initial begin
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_digits", 32'(digits_out), 32'h0);
    check("rst_blank", 32'(blank_out), 32'h3F);
    check("rst_dp", 32'(dp_out), 32'h0);
    rst_n = 1'b1;
    hold(8'hFF, '1, 20);

    // Full sweep of digits 0..5
    f0 = fv_cnt;
    send_range(0, 5);
    check("sweep_frames", 32'(fv_cnt - f0), 32'd1);
    check("sweep_digits", 32'(digits_out), 32'h543210);
    check("sweep_blank", 32'(blank_out), 32'h0);
    check("sweep_dp", 32'(dp_out), 32'h0);

    // Digit 2 blank with decimal point lit
    f0 = fv_cnt;
    send_range(0, 1);
    hold(8'h7F, 6'h3B, 20);
    send_range(3, 5);
    check("blank_frames", 32'(fv_cnt - f0), 32'd1);
    check("blank_digits", 32'(digits_out), 32'h543010);
    check("blank_blank", 32'(blank_out), 32'h04);
    check("blank_dp", 32'(dp_out), 32'h04);

    // 15 clocks is one short of acceptance; 16 is enough
    f0 = fv_cnt;
    hold(SEGS[0], ANS[0], 15);
    send_range(1, 5);
    check("short_frames", 32'(fv_cnt - f0), 32'd0);
    hold(SEGS[0], ANS[0], 16);
    hold(8'hFF, '1, 4);
    check("exact_frames", 32'(fv_cnt - f0), 32'd1);
    check("exact_digits", 32'(digits_out), 32'h543210);

    // Unknown pattern on digit 0
    f0 = fv_cnt; d0 = de_cnt;
    hold(8'hFE, ANS[0], 20);
    hold(8'hFF, '1, 4);
    check("deerr_pulses", 32'(de_cnt - d0), 32'd1);
    send_range(1, 5);
    check("deerr_noframe", 32'(fv_cnt - f0), 32'd0);
    send_range(0, 0);
    check("deerr_frame", 32'(fv_cnt - f0), 32'd1);

    // Two anodes active, then none active
    f0 = fv_cnt; d0 = de_cnt; a0 = ae_cnt;
    hold(SEGS[0], 6'h3C, 20);
    hold(8'hFF, '1, 4);
    check("anerr_pulses", 32'(ae_cnt - a0), 32'd1);
    a0 = ae_cnt;
    hold(SEGS[0], 6'h3F, 20);
    check("idle_anerr", 32'(ae_cnt - a0), 32'd0);
    check("idle_deerr", 32'(de_cnt - d0), 32'd0);
    send_range(1, 5);
    check("anerr_noframe", 32'(fv_cnt - f0), 32'd0);
    send_range(0, 0);
    check("anerr_frame", 32'(fv_cnt - f0), 32'd1);

    // Reset mid-frame discards partial progress
    send_range(0, 2);
    rst_n = 1'b0;
    hold(8'hFF, '1, 2);
    check("mid_rst_digits", 32'(digits_out), 32'h0);
    check("mid_rst_blank", 32'(blank_out), 32'h3F);
    rst_n = 1'b1;
    f0 = fv_cnt;
    send_range(3, 5);
    check("rst_noframe", 32'(fv_cnt - f0), 32'd0);
    send_range(0, 5);
    check("rst_frame", 32'(fv_cnt - f0), 32'd1);
    check("rst_frame_digits", 32'(digits_out), 32'h543210);

    hold(8'hFF, '1, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
